// File: rtl/cpu8_datapath.sv
// cpu8_datapath: register/ALU datapath for the 8-bit processor.
//
// The controller drives the control word each cycle. This block holds PC, IR, AC, R,
// AH/AL and Z, computes the ALU result and selects the memory address. It returns
// opcode (IR) and zflag to the controller.
//
// Optional feature: define CPU8_CARRY_FLAG_EN to add the carry/borrow flag output cflag.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   buffIR/AH/AL       load IR/AH/AL from readdata
//   buffR              load R from AC
//   srcbmux            ALU operand B: 0 = R, 1 = 8'h01
//   adrmux             address select: 0 = PC, 1 = {AH,AL}
//   we                 memory write request (passed through as memwe)
//   pcmux              00/11 hold, 01 increment, 10 jump to {AH,AL}
//   acmux              00 ALU (if aluop != 0), 01 readdata, 10 R, 11 hold
//   aluop              000 none, ADD, SUB, CLR, AND, OR, XOR, NOT
//   readdata           memory read data (combinational from adr)
//   adr, writedata     memory address and write data (AC)
//   memwe, opcode      write enable, IR contents
//   zflag [, cflag]    zero flag [, carry/borrow flag]
module cpu8_datapath #(
    parameter int unsigned    AW       = 16,
    parameter int unsigned    DW       = 8,
    parameter logic [AW-1:0]  RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          buffIR,
    input  logic          buffAH,
    input  logic          buffAL,
    input  logic          buffR,
    input  logic          srcbmux,
    input  logic          adrmux,
    input  logic          we,
    input  logic [1:0]    pcmux,
    input  logic [1:0]    acmux,
    input  logic [2:0]    aluop,
    input  logic [DW-1:0] readdata,
    output logic [AW-1:0] adr,
    output logic [DW-1:0] writedata,
    output logic          memwe,
    output logic [DW-1:0] opcode,
`ifdef CPU8_CARRY_FLAG_EN
    output logic          zflag,
    output logic          cflag
`else
    output logic          zflag
`endif
);

    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q;
    logic [DW-1:0] ac_q, ac_d;
    logic          ac_we;
    logic [DW-1:0] r_q;
    logic [DW-1:0] ah_q;
    logic [DW-1:0] al_q;
    logic          z_q;

    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_res;
`ifdef CPU8_CARRY_FLAG_EN
    logic          c_q;
    logic          alu_carry;
`endif

    // Combinational outputs
    assign adr       = adrmux ? {ah_q, al_q} : pc_q;
    assign memwe     = we;
    assign writedata = ac_q;
    assign opcode    = ir_q;
    assign zflag     = z_q;
`ifdef CPU8_CARRY_FLAG_EN
    assign cflag     = c_q;
`endif

    // ALU
    always_comb begin
        alu_b   = srcbmux ? DW'(1) : r_q;
        alu_res = ac_q;
`ifdef CPU8_CARRY_FLAG_EN
        alu_carry = 1'b0;
`endif
        case (aluop)
`ifdef CPU8_CARRY_FLAG_EN
            // Bit DW of the widened sum/difference is the carry-out / borrow.
            3'b001:  {alu_carry, alu_res} = {1'b0, ac_q} + {1'b0, alu_b};
            3'b010:  {alu_carry, alu_res} = {1'b0, ac_q} - {1'b0, alu_b};
`else
            3'b001:  alu_res = ac_q + alu_b;
            3'b010:  alu_res = ac_q - alu_b;
`endif
            3'b011:  alu_res = '0;
            3'b100:  alu_res = ac_q & alu_b;
            3'b101:  alu_res = ac_q | alu_b;
            3'b110:  alu_res = ac_q ^ alu_b;
            3'b111:  alu_res = ~ac_q;
            default: alu_res = ac_q;
        endcase
    end

    // AC write selection; acmux takes priority over aluop
    always_comb begin
        ac_we = 1'b0;
        ac_d  = ac_q;
        case (acmux)
            2'b01: begin
                ac_we = 1'b1;
                ac_d  = readdata;
            end
            2'b10: begin
                ac_we = 1'b1;
                ac_d  = r_q;
            end
            2'b11: begin
                ac_we = 1'b0;
            end
            default: begin
                if (aluop != 3'b000) begin
                    ac_we = 1'b1;
                    ac_d  = alu_res;
                end
            end
        endcase
    end

    // PC next state
    always_comb begin
        pc_d = pc_q;
        case (pcmux)
            2'b01:   pc_d = pc_q + AW'(1);
            2'b10:   pc_d = {ah_q, al_q};
            default: pc_d = pc_q;
        endcase
    end

    // All loads sample pre-edge values, so R <= AC with an AC write swaps cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
            ir_q <= '0;
            ac_q <= '0;
            r_q  <= '0;
            ah_q <= '0;
            al_q <= '0;
            z_q  <= 1'b1;
`ifdef CPU8_CARRY_FLAG_EN
            c_q  <= 1'b0;
`endif
        end else begin
            pc_q <= pc_d;
            if (buffIR) ir_q <= readdata;
            if (buffAH) ah_q <= readdata;
            if (buffAL) al_q <= readdata;
            if (buffR)  r_q  <= ac_q;
            if (ac_we) begin
                ac_q <= ac_d;
                z_q  <= (ac_d == '0);
            end
`ifdef CPU8_CARRY_FLAG_EN
            // Only ALU writes touch the carry; memory and R loads leave it alone.
            if (ac_we && (acmux == 2'b00)) c_q <= alu_carry;
`endif
        end
    end

endmodule

// File: tb/tb_cpu8_datapath.sv
// Self-checking bench for cpu8_datapath: directed test-plan sequence followed by
// randomized control words, all checked against a behavioural model.
module tb_cpu8_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        buffIR, buffAH, buffAL, buffR;
    logic        srcbmux, adrmux, we;
    logic [1:0]  pcmux, acmux;
    logic [2:0]  aluop;
    logic [7:0]  readdata;
    logic [15:0] adr;
    logic [7:0]  writedata;
    logic        memwe;
    logic [7:0]  opcode;
    logic        zflag;
`ifdef CPU8_CARRY_FLAG_EN
    logic        cflag;
`endif

    always #5 clk = ~clk;

    cpu8_datapath #(
        .AW       (16),
        .DW       (8),
        .RESET_PC (16'h0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .buffIR    (buffIR),
        .buffAH    (buffAH),
        .buffAL    (buffAL),
        .buffR     (buffR),
        .srcbmux   (srcbmux),
        .adrmux    (adrmux),
        .we        (we),
        .pcmux     (pcmux),
        .acmux     (acmux),
        .aluop     (aluop),
        .readdata  (readdata),
        .adr       (adr),
        .writedata (writedata),
        .memwe     (memwe),
        .opcode    (opcode),
`ifdef CPU8_CARRY_FLAG_EN
        .zflag     (zflag),
        .cflag     (cflag)
`else
        .zflag     (zflag)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    logic [15:0] m_pc;
    logic [7:0]  m_ir, m_ac, m_r, m_ah, m_al;
    logic        m_z, m_c;

    task automatic model_check();
        check_eq("adr", 32'(adr), adrmux ? {16'h0, m_ah, m_al} : {16'h0, m_pc});
        check_eq("memwe", 32'(memwe), 32'(we));
        check_eq("writedata", 32'(writedata), 32'(m_ac));
        check_eq("opcode", 32'(opcode), 32'(m_ir));
        check_eq("zflag", 32'(zflag), 32'(m_z));
`ifdef CPU8_CARRY_FLAG_EN
        check_eq("cflag", 32'(cflag), 32'(m_c));
`endif
    endtask

    // Next state from the architectural rules, using only pre-edge values.
    task automatic model_next();
        int a, b, res;
        logic       wr, nc;
        logic [7:0] nac, nr, nir, nah, nal;
        logic [15:0] npc;
        if (reset) begin
            m_pc = 16'h0000; m_ir = 0; m_ac = 0; m_r = 0; m_ah = 0; m_al = 0;
            m_z = 1'b1; m_c = 1'b0;
            return;
        end
        a   = int'(m_ac);
        b   = srcbmux ? 1 : int'(m_r);
        wr  = 1'b0;
        nac = m_ac;
        nc  = m_c;
        if (acmux == 2'd1) begin
            wr = 1'b1; nac = readdata;
        end else if (acmux == 2'd2) begin
            wr = 1'b1; nac = m_r;
        end else if (acmux == 2'd0 && aluop != 3'd0) begin
            wr = 1'b1;
            nc = 1'b0;
            case (aluop)
                3'd1: begin res = a + b; nac = 8'(res % 256); nc = (res > 255); end
                3'd2: begin res = a - b; nac = 8'((res + 256) % 256); nc = (a < b); end
                3'd3: nac = 8'h00;
                3'd4: nac = 8'(a & b);
                3'd5: nac = 8'(a | b);
                3'd6: nac = 8'(a ^ b);
                default: nac = 8'(255 - a);
            endcase
        end
        nr  = buffR  ? m_ac : m_r;
        nir = buffIR ? readdata : m_ir;
        nah = buffAH ? readdata : m_ah;
        nal = buffAL ? readdata : m_al;
        npc = m_pc;
        if (pcmux == 2'd1) npc = 16'((int'(m_pc) + 1) % 65536);
        else if (pcmux == 2'd2) npc = {m_ah, m_al};
        m_pc = npc; m_ir = nir; m_r = nr; m_ah = nah; m_al = nal;
        if (wr) begin
            m_ac = nac;
            m_z  = (nac == 8'h00);
            m_c  = nc;
        end
    endtask

    // One clock: check settled outputs, advance model, return 1 time unit after the edge.
    task automatic cycle(input bit chk);
        #2;
        if (chk) model_check();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; buffIR = 0; buffAH = 0; buffAL = 0; buffR = 0;
        srcbmux = 0; adrmux = 0; we = 0; pcmux = 2'd0; acmux = 2'd0; aluop = 3'd0;
        readdata = 8'h00;
    endtask

    task automatic load_ac(input logic [7:0] v);
        idle(); acmux = 2'd1; readdata = v; cycle(1);
    endtask

    task automatic alu_op(input logic [2:0] op, input logic sb);
        idle(); aluop = op; srcbmux = sb; cycle(1);
    endtask

    initial begin
        idle();
        reset = 1;
        cycle(0);

        // Move PC away from zero, then reset while an increment is requested
        idle(); pcmux = 2'd1; cycle(1); cycle(1); cycle(1);
        idle(); reset = 1; pcmux = 2'd1; cycle(1);
        idle();
        #1;
        check_eq("rst_adr", 32'(adr), 32'h0000);
        check_eq("rst_ac", 32'(writedata), 32'h00);
        check_eq("rst_z", 32'(zflag), 32'h1);

        // LDAC path
        idle(); buffAH = 1; readdata = 8'h12; cycle(1);
        idle(); buffAL = 1; readdata = 8'h34; cycle(1);
        idle(); adrmux = 1; acmux = 2'd1; readdata = 8'h00;
        #1 check_eq("ldac_adr", 32'(adr), 32'h1234);
        cycle(1);
        check_eq("ldac_ac0", 32'(writedata), 32'h00);
        check_eq("ldac_z0", 32'(zflag), 32'h1);
        idle(); adrmux = 1; acmux = 2'd1; readdata = 8'h5A; cycle(1);
        check_eq("ldac_ac5a", 32'(writedata), 32'h5A);
        check_eq("ldac_z5a", 32'(zflag), 32'h0);

        // ALU: AC=FF, R=01
        load_ac(8'h01);
        idle(); buffR = 1; cycle(1);
        load_ac(8'hFF);
        alu_op(3'd1, 1'b0);
        check_eq("add_ac", 32'(writedata), 32'h00);
        check_eq("add_z", 32'(zflag), 32'h1);
`ifdef CPU8_CARRY_FLAG_EN
        check_eq("add_c", 32'(cflag), 32'h1);
`endif
        alu_op(3'd1, 1'b1);
        check_eq("inac_ac", 32'(writedata), 32'h01);
        check_eq("inac_z", 32'(zflag), 32'h0);
        load_ac(8'h02);
        idle(); buffR = 1; cycle(1);
        load_ac(8'h01);
        alu_op(3'd2, 1'b0);
        check_eq("sub_ac", 32'(writedata), 32'hFF);
`ifdef CPU8_CARRY_FLAG_EN
        check_eq("sub_c", 32'(cflag), 32'h1);
`endif
        alu_op(3'd7, 1'b0);
        check_eq("not_ac", 32'(writedata), 32'h00);
        check_eq("not_z", 32'(zflag), 32'h1);

        // Jump to FFFF, then wrap
        idle(); buffAH = 1; buffAL = 1; readdata = 8'hFF; cycle(1);
        idle(); pcmux = 2'd2; cycle(1);
        check_eq("jmp_ffff", 32'(adr), 32'hFFFF);
        idle(); pcmux = 2'd1; cycle(1);
        check_eq("pc_wrap", 32'(adr), 32'h0000);
        idle(); buffAH = 1; readdata = 8'hAB; cycle(1);
        idle(); buffAL = 1; readdata = 8'hCD; cycle(1);
        idle(); pcmux = 2'd2; cycle(1);
        check_eq("jmp_abcd", 32'(adr), 32'hABCD);

        // Store and hold
        load_ac(8'h3C);
        idle(); adrmux = 1; we = 1;
        #1;
        check_eq("st_memwe", 32'(memwe), 32'h1);
        check_eq("st_wdata", 32'(writedata), 32'h3C);
        check_eq("st_adr", 32'(adr), 32'hABCD);
        cycle(1);
        idle(); cycle(1);
        check_eq("hold_ac", 32'(writedata), 32'h3C);
        check_eq("hold_z", 32'(zflag), 32'h0);

        // Swap AC and R (R holds 02 here)
        idle(); buffR = 1; acmux = 2'd2; cycle(1);
        check_eq("swap_ac", 32'(writedata), 32'h02);
        idle(); acmux = 2'd2; cycle(1);
        check_eq("swap_r", 32'(writedata), 32'h3C);

        // Reset during a jump
        idle(); reset = 1; pcmux = 2'd2; cycle(1);
        idle();
        #1 check_eq("rst_jmp", 32'(adr), 32'h0000);

        // Randomized control words
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 63) == 0);
            buffIR   = 1'($urandom_range(0, 1));
            buffAH   = 1'($urandom_range(0, 1));
            buffAL   = 1'($urandom_range(0, 1));
            buffR    = 1'($urandom_range(0, 1));
            srcbmux  = 1'($urandom_range(0, 1));
            adrmux   = 1'($urandom_range(0, 1));
            we       = 1'($urandom_range(0, 1));
            pcmux    = 2'($urandom_range(0, 3));
            acmux    = 2'($urandom_range(0, 3));
            aluop    = 3'($urandom_range(0, 7));
            readdata = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            cycle(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu8_datapath.md
Name: cpu8_datapath

Overview:
- Register/ALU datapath that consumes the control word from the 8-bit processor controller and returns `opcode` and `zflag` to it.
- Holds PC, IR, AC, R, the AH/AL address buffers and the Z flag, plus the ALU and the address mux.
- Drives a byte-wide memory port with combinational read.
- Sits directly downstream of the controller and upstream of instruction/data memory.

Parameters:
- AW, 16, address width; AR = {AH,AL} is 2x8 bits, so AW must be 16.
- DW, 8, data width of AC, R, IR and the memory bus.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- buffIR  in  1  IR <= readdata.
- buffAH  in  1  AH <= readdata.
- buffAL  in  1  AL <= readdata.
- buffR  in  1  R <= AC.
- srcbmux  in  1  ALU operand B: 0 = R, 1 = 8'h01.
- adrmux  in  1  address: 0 = PC, 1 = {AH,AL}.
- we  in  1  memory write request.
- pcmux  in  2  00 hold, 01 PC+1, 10 PC <= {AH,AL}, 11 hold.
- acmux  in  2  00 ALU result (gated by aluop), 01 readdata, 10 R, 11 no write.
- aluop  in  3  000 none, 001 ADD, 010 SUB, 011 CLR, 100 AND, 101 OR, 110 XOR, 111 NOT.
- readdata  in  8  memory read data, combinational from adr.
- adr  out  16  memory address.
- writedata  out  8  always AC.
- memwe  out  1  equals `we`.
- opcode  out  8  IR contents.
- zflag  out  1  Z flag register.

Behaviour:
- Reset (sync, active-high):
  - PC = RESET_PC; IR, AC, R, AH, AL = 0; Z = 1.
  - Reset overrides every control input in the same cycle.
- adr = adrmux ? {AH,AL} : PC, combinational.
- memwe = we, combinational, no qualification.
- Register loads are independent and may coincide in one cycle:
  - All sources are sampled before the edge.
  - buffR with an AC write: R gets the old AC.
  - buffAH and buffAL together: both get the same readdata.
- PC:
  - 01: PC+1 mod 2^16; FFFF wraps to 0000.
  - 10: PC <= {AH,AL}, using AH/AL values before this edge.
  - 00 and 11: PC holds.
- AC write selection, in priority order:
  - acmux=01: AC <= readdata.
  - acmux=10: AC <= R.
  - acmux=11: AC holds.
  - acmux=00 and aluop!=000: AC <= ALU result.
  - acmux=00 and aluop=000: AC holds.
- ALU, with B = srcbmux ? 8'h01 : R:
  - ADD: AC+B mod 256.
  - SUB: AC-B mod 256.
  - CLR: 8'h00.
  - AND / OR / XOR: AC op B.
  - NOT: ~AC.
- Z flag:
  - Updated only when AC is written: Z <= (new AC == 8'h00).
  - Otherwise Z holds, including on stores, R writes and PC changes.
- No internal FSM: sequencing belongs to the controller. All register state is edge-triggered; the only combinational paths are adr, memwe, writedata and the ALU.
- Latency:
  - opcode is visible the cycle after buffIR.
  - zflag is visible the cycle after the AC write.
  - No combinational path from readdata to opcode or zflag.

Optional Feature:
- Macro CPU8_CARRY_FLAG_EN.
- When defined:
  - Adds output `cflag` (1 bit), reset to 0.
  - ADD: cflag = carry-out of the 9-bit sum.
  - SUB: cflag = borrow (AC < B).
  - Other ALU ops that write AC clear cflag.
  - acmux 01/10 loads leave cflag unchanged.
- When undefined: no `cflag` port and no carry logic. All other behaviour is identical.

Test Plan:
- Reset: assert reset for 1 cycle with pcmux=01 -> PC=0000, AC=00, zflag=1, adr=0000 next cycle.
- LDAC path:
  - Stimulus: readdata=12, buffAH=1; then readdata=34, buffAL=1; then adrmux=1, acmux=01, readdata=00.
  - Required: adr=1234, AC=00, zflag=1.
  - Repeat with readdata=5A -> AC=5A, zflag=0.
- ALU:
  - Setup: AC=FF, R=01 (buffR from AC=01, then reload AC).
  - ADD -> AC=00, zflag=1 (cflag=1 if enabled).
  - INAC (srcbmux=1, aluop=001) -> AC=01, zflag=0.
  - SUB of 02 -> AC=FF (cflag=1 if enabled).
  - NOT -> AC=00.
- Jump and PC wrap:
  - PC=FFFF, pcmux=01 -> PC=0000.
  - AH=AB, AL=CD, pcmux=10 -> PC=ABCD, adr=ABCD with adrmux=0.
- Store and hold:
  - AC=3C, adrmux=1, we=1 -> memwe=1, writedata=3C, adr={AH,AL}.
  - acmux=00, aluop=000 -> AC and zflag unchanged.
- Simultaneous and reset-mid-op:
  - buffR=1 with acmux=10 -> R=old AC, AC=old R (swap).
  - reset asserted during a pcmux=10 cycle -> PC=RESET_PC, not {AH,AL}.
